// File: rtl/xor_rr_sched.sv
// xor_rr_sched: round-robin arbiter time-sharing one bit-serial XOR cell.
// Define XOR_SCHED_PARITY_EN to add the res_par output.

module xor_nand_cell (
    input  logic a,
    input  logic b,
    output logic y
);
    logic n0;
    logic n1;
    logic n2;

    assign n0 = ~(a & b);
    assign n1 = ~(a & n0);
    assign n2 = ~(b & n0);
    assign y  = ~(n1 & n2);
endmodule

module xor_rr_sched #(
    parameter  int NREQ = 4,
    parameter  int W    = 8,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] op_a,
    input  logic [NREQ*W-1:0] op_b,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic [W-1:0]      res,
    output logic [IDW-1:0]    res_id,
    output logic              res_valid
`ifdef XOR_SCHED_PARITY_EN
    ,
    output logic              res_par
`endif
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t         state;
    logic [W-1:0]   sa;
    logic [W-1:0]   sb;
    logic [W-1:0]   sr;
    logic [CW-1:0]  cnt;
    logic [IDW-1:0] sel;
    logic [IDW-1:0] last;
    logic [IDW-1:0] pick;
    logic [IDW-1:0] idx;
    logic           found;
    logic           xbit;
    logic [W:0]     sr_cat;
    logic [W-1:0]   sr_nxt;
    logic [W-1:0]   av [NREQ];
    logic [W-1:0]   bv [NREQ];
`ifdef XOR_SCHED_PARITY_EN
    logic           pacc;
`endif

    xor_nand_cell u_cell (
        .a (sa[0]),
        .b (sb[0]),
        .y (xbit)
    );

    // New bit enters at the MSB so the LSB-first stream lands in order.
    assign sr_cat = {xbit, sr};
    assign sr_nxt = sr_cat[W:1];

    // Unpack the flat operand buses into per-requester words.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            av[i] = op_a[i*W +: W];
            bv[i] = op_b[i*W +: W];
        end
    end

    // Round-robin pick: first request above the last grant, wrapping.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(last) + k) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Sequencer: arbitrate in IDLE, shift W bits in BUSY, publish in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sa        <= '0;
            sb        <= '0;
            sr        <= '0;
            cnt       <= '0;
            sel       <= '0;
            last      <= IDW'(NREQ - 1);
            gnt       <= '0;
            busy      <= 1'b0;
            res       <= '0;
            res_id    <= '0;
            res_valid <= 1'b0;
`ifdef XOR_SCHED_PARITY_EN
            pacc      <= 1'b0;
            res_par   <= 1'b0;
`endif
        end else begin
            gnt       <= '0;
            res_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        sa        <= av[pick];
                        sb        <= bv[pick];
                        sr        <= '0;
                        cnt       <= CW'(W - 1);
                        sel       <= pick;
                        last      <= pick;
                        gnt[pick] <= 1'b1;
                        busy      <= 1'b1;
                        state     <= BUSY;
`ifdef XOR_SCHED_PARITY_EN
                        pacc      <= 1'b0;
`endif
                    end
                end
                BUSY: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sr  <= sr_nxt;
                    cnt <= cnt - 1'b1;
`ifdef XOR_SCHED_PARITY_EN
                    pacc <= pacc ^ xbit;
`endif
                    if (cnt == '0) begin
                        res       <= sr_nxt;
                        res_id    <= sel;
                        res_valid <= 1'b1;
                        state     <= DONE;
`ifdef XOR_SCHED_PARITY_EN
                        res_par   <= pacc ^ xbit;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_xor_rr_sched.sv
// tb_xor_rr_sched: randomized bench for xor_rr_sched against a
// behavioural model (result a^b, pointer round-robin, cycle timing).

module tb_xor_rr_sched;
    localparam int NREQ = 4;
    localparam int W    = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] op_a;
    logic [NREQ*W-1:0] op_b;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic [W-1:0]      res;
    logic [1:0]        res_id;
    logic              res_valid;

    logic [1:0]        req1;
    logic [1:0]        a1;
    logic [1:0]        b1;
    logic [1:0]        gnt1;
    logic              busy1;
    logic [0:0]        res1;
    logic [0:0]        res_id1;
    logic              res_valid1;
`ifdef XOR_SCHED_PARITY_EN
    logic              res_par;
    logic              res_par1;
`endif

    xor_rr_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .gnt       (gnt),
        .busy      (busy),
        .res       (res),
        .res_id    (res_id),
        .res_valid (res_valid)
`ifdef XOR_SCHED_PARITY_EN
        ,
        .res_par   (res_par)
`endif
    );

    xor_rr_sched #(.NREQ(2), .W(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .req       (req1),
        .op_a      (a1),
        .op_b      (b1),
        .gnt       (gnt1),
        .busy      (busy1),
        .res       (res1),
        .res_id    (res_id1),
        .res_valid (res_valid1)
`ifdef XOR_SCHED_PARITY_EN
        ,
        .res_par   (res_par1)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int m_last = NREQ - 1;
    int gcyc = 0;
    int gcyc_prev = 0;
    logic [W-1:0] ma [NREQ];
    logic [W-1:0] mb [NREQ];

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h",
                     tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r,
                                   input int from);
        for (int k = 1; k <= NREQ; k++)
            if (r[(from + k) % NREQ]) return (from + k) % NREQ;
        return -1;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < NREQ; i++) begin
            op_a[i*W +: W] = ma[i];
            op_b[i*W +: W] = mb[i];
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            ma[i] = W'($urandom);
            mb[i] = W'($urandom);
        end
    endtask

    // One arbitrated operation, entered and left at an IDLE negedge.
    task automatic op(input logic [NREQ-1:0] r, input bit scr);
        int id;
        int n;
        bit got;
        logic [W-1:0] er;
        id = rr_pick(r, m_last);
        m_last = id;
        er = ma[id] ^ mb[id];
        drive_ops();
        req = r;
        @(negedge clk);
        check("gnt", 64'(gnt), 64'(1) << id);
        check("busy_gnt", 64'(busy), 1);
        gcyc_prev = gcyc;
        gcyc = cyc;
        req[id] = 1'b0;
        n = 0;
        got = 0;
        while (!got && n < W + 4) begin
            if (scr) begin
                rand_ops();
                drive_ops();
                req[1] = ~req[1];
            end
            @(negedge clk);
            n++;
            if (res_valid) got = 1;
            else begin
                check("busy_run", 64'(busy), 1);
                check("gnt_quiet", 64'(gnt), 0);
            end
        end
        check("latency", 64'(n), 64'(W));
        check("res", 64'(res), 64'(er));
        check("res_id", 64'(res_id), 64'(id));
        check("busy_done", 64'(busy), 1);
`ifdef XOR_SCHED_PARITY_EN
        check("res_par", 64'(res_par), 64'(^er));
`endif
        @(negedge clk);
        check("rv_pulse", 64'(res_valid), 0);
        check("busy_idle", 64'(busy), 0);
        check("res_hold", 64'(res), 64'(er));
        req = '0;
    endtask

    // Grant requester set r, then reset on the 4th BUSY cycle.
    task automatic abort_op(input logic [NREQ-1:0] r);
        int id;
        id = rr_pick(r, m_last);
        drive_ops();
        req = r;
        @(negedge clk);
        check("abort_gnt", 64'(gnt), 64'(1) << id);
        req = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_last = NREQ - 1;
        check("abort_busy", 64'(busy), 0);
        check("abort_res", 64'(res), 0);
        check("abort_id", 64'(res_id), 0);
        check("abort_rv", 64'(res_valid), 0);
`ifdef XOR_SCHED_PARITY_EN
        check("abort_par", 64'(res_par), 0);
`endif
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            check("abort_no_rv", 64'(res_valid), 0);
        end
    endtask

    initial begin
        logic [NREQ-1:0] pending;
        rst  = 1'b1;
        req  = '0;
        op_a = '0;
        op_b = '0;
        req1 = '0;
        a1   = '0;
        b1   = '0;
        rand_ops();
        repeat (2) @(negedge clk);
        check("rst_gnt", 64'(gnt), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_res", 64'(res), 0);
        check("rst_id", 64'(res_id), 0);
        check("rst_rv", 64'(res_valid), 0);
        check("rst_busy1", 64'(busy1), 0);
        rst = 1'b0;
        @(negedge clk);

        // W=1 instance: result one cycle after grant.
        req1 = 2'b01;
        a1   = 2'b11;
        b1   = 2'b11;
        @(negedge clk);
        check("w1_gnt0", 64'(gnt1), 1);
        req1 = 2'b00;
        @(negedge clk);
        check("w1_rv0", 64'(res_valid1), 1);
        check("w1_res0", 64'(res1), 0);
        check("w1_id0", 64'(res_id1), 0);
        @(negedge clk);
        check("w1_idle", 64'(busy1), 0);
        req1 = 2'b10;
        a1   = 2'b10;
        b1   = 2'b00;
        @(negedge clk);
        check("w1_gnt1", 64'(gnt1), 2);
        req1 = 2'b00;
        @(negedge clk);
        check("w1_rv1", 64'(res_valid1), 1);
        check("w1_res1", 64'(res1), 1);
        check("w1_id1", 64'(res_id1), 1);
`ifdef XOR_SCHED_PARITY_EN
        check("w1_par1", 64'(res_par1), 1);
`endif
        @(negedge clk);

        // All four requesting: 0,1,2,3 spaced W+2 cycles apart.
        pending = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            rand_ops();
            op(pending, 1'b0);
            if (i > 0)
                check("rr_gap", 64'(gcyc - gcyc_prev), 64'(W + 2));
            pending[m_last] = 1'b0;
        end
        rand_ops();
        op(4'b1001, 1'b0);
        check("rr_wrap", 64'(m_last), 0);
        op(4'b1000, 1'b0);

        // Directed operands, including all-ones / all-zeros.
        ma[0] = 8'hA5; mb[0] = 8'h3C;
        op(4'b0001, 1'b0);
        ma[2] = 8'hFF; mb[2] = 8'hFF;
        op(4'b0100, 1'b0);
        ma[3] = 8'hFF; mb[3] = 8'h00;
        op(4'b1000, 1'b0);
        ma[1] = 8'h01; mb[1] = 8'h00;
        op(4'b0010, 1'b0);

        // Operand and req churn while busy must not leak in.
        rand_ops();
        op(4'b0100, 1'b1);

        for (int i = 0; i < 30; i++) begin
            rand_ops();
            op(NREQ'($urandom_range(1, (1 << NREQ) - 1)), (i % 5) == 0);
        end

        // Abort mid-run; pointer returns to NREQ-1.
        ma[0] = 8'hA5; mb[0] = 8'h3C;
        op(4'b0001, 1'b0);
        rand_ops();
        abort_op(4'b0010);
        op(4'b0110, 1'b0);
        check("post_rst_pick", 64'(m_last), 1);
        op(4'b0110, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/xor_rr_sched.md
Name: xor_rr_sched

Overview:
- Round-robin scheduler sharing one bit-serial XOR engine (single 1-bit NAND-built XOR cell) among NREQ requesters.
- Each requester presents two W-bit operands. The block grants one requester, latches its operands and shifts them LSB-first through the XOR cell for W cycles. It then returns the W-bit result tagged with the requester index.
- Sits between client logic and the shared gate-level XOR datapath; it is the only driver of that cell.

Parameters:
- NREQ, 4, number of requesters (>=2).
- W, 8, operand/result width in bits (>=1).
- IDW, $clog2(NREQ), width of res_id (derived local parameter).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  NREQ  per-requester request; held until granted.
- op_a  in  NREQ*W  operand A; requester i occupies bits [i*W +: W].
- op_b  in  NREQ*W  operand B; same packing as op_a.
- gnt  out  NREQ  one-hot grant; one-cycle pulse.
- busy  out  1  high whenever state != IDLE.
- res  out  W  result a^b; holds its value until the next completion.
- res_id  out  IDW  index of the requester that owns res.
- res_valid  out  1  one-cycle completion pulse.

Behaviour:
- One clock domain; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset values:
  - State IDLE; gnt=0, busy=0, res=0, res_id=0, res_valid=0.
  - Shift registers and counter cleared.
  - Last-grant pointer = NREQ-1, so requester 0 has top priority after reset.
- FSM states:
  - IDLE: req is sampled only here. If req!=0 at edge E0, pick the first set bit searching upward from (last+1) mod NREQ, wrapping. At E0: latch that requester's op_a/op_b into shift regs sa/sb, set cnt=W-1, update the last-grant pointer, go to BUSY. If req==0, stay in IDLE.
  - BUSY: gnt[sel]=1 in the first BUSY cycle only. Each edge:
    - the XOR cell computes sa[0]^sb[0];
    - the bit shifts into the result shift reg from the MSB side;
    - sa and sb shift right;
    - cnt decrements.
    - At the edge where cnt==0, load res from the shift reg plus the final bit, load res_id=sel, set res_valid=1, go to DONE.
  - DONE: res_valid high for this one cycle; go to IDLE at the next edge.
- Timing:
  - gnt appears in the cycle after the sampling edge.
  - res_valid appears W cycles after the gnt cycle.
  - Minimum request-to-request period per grant is W+2 edges.
- Requester obligations and changes after grant:
  - A requester drops req on seeing gnt.
  - req or operand changes after E0 do not affect the operation in flight.
  - req changes during BUSY/DONE are ignored.
- Simultaneous requests: strict round-robin. A requester granted last has lowest priority next time.
- Only one operation is in flight; no queuing.
- Reset mid-operation:
  - Abort; next cycle state is IDLE with all outputs at reset values.
  - No res_valid is produced for the aborted operation.
  - The pointer is reset.

Optional Feature:
- Macro XOR_SCHED_PARITY_EN.
- Defined:
  - Adds output res_par (1 bit), the XOR-reduction of the result.
  - Accumulated serially in the same W shift cycles; valid with res_valid; updates together with res.
  - Reset value 0; reset mid-operation clears the accumulator.
- Undefined: port res_par and its accumulator are absent; all other behaviour is identical.

Test Plan:
1. NREQ=4, W=8. req=0001, a0=0xA5, b0=0x3C -> gnt=0001 one cycle after the sampling edge; res_valid 8 cycles after gnt, lasting 1 cycle; res=0x99, res_id=0; busy high for 9 cycles.
2. req=1111 held, each requester dropping its req on its own gnt -> grants 0,1,2,3 each 10 cycles apart. Then req=1001 -> requester 0 is granted before 3 (pointer at 3).
3. Boundary operands: a=b=0xFF -> res=0x00. a=0xFF, b=0x00 -> res=0xFF. W=1 build with a=1, b=1 -> res=0, res_valid 1 cycle after gnt.
4. After gnt for requester 2, change op_a2/op_b2 and toggle req[1] during BUSY -> res equals the originally latched a^b; no grant occurs until DONE->IDLE.
5. rst asserted on the 4th BUSY cycle for one cycle -> next cycle busy=0, res=0, res_valid never pulses. With req=0110 pending, requester 1 is granted first.
6. With XOR_SCHED_PARITY_EN: a=0xA5, b=0x3C -> res_par=0. a=0x01, b=0x00 -> res_par=1. Without the macro the bench compiles without res_par and results match.
